// File: rtl/lfsr_pkg.sv
// Shared types, default taps and the XNOR Fibonacci step function for the LFSR random source.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} lfsr_state_e;

  localparam logic [9:0] LFSR10_TAPS = 10'h240;
  localparam int LFSR_MAX_W = 32;

  // Operates on a zero-extended state of 'width' significant bits; caller truncates.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] taps,
                                                      input int unsigned width);
    logic [LFSR_MAX_W-1:0] mask;
    logic fb;
    mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
    fb = ~^(state & taps & mask);
    return ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: seed load, single-step shift, optional all-ones recovery.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR10_TAPS),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] raw,
  output logic             lockup
);

  logic [WIDTH-1:0] nxt;
  assign nxt = WIDTH'(lfsr_next(LFSR_MAX_W'(raw), LFSR_MAX_W'(TAPS), WIDTH));

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic stuck;
  assign stuck = (raw == {WIDTH{1'b1}});

  // All-ones is a fixed point of the XNOR feedback; escape to zero on the next shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw    <= SEED_DEFAULT;
      lockup <= 1'b0;
    end else if (load) begin
      raw    <= seed;
      lockup <= 1'b0;
    end else if (step && stuck) begin
      raw    <= '0;
      lockup <= 1'b1;
    end else begin
      if (step) raw <= nxt;
      lockup <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     raw <= SEED_DEFAULT;
    else if (load) raw <= seed;
    else if (step) raw <= nxt;
  end

  assign lockup = 1'b0;
`endif

endmodule

// File: rtl/lfsr_rand_range.sv
// LFSR random source with raw output and a rejection-sampled bounded draw (req/rand_valid).
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (all-ones lock-up recovery in lfsr_core).
module lfsr_rand_range
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR10_TAPS),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = '0,
  parameter int unsigned RANGE_MIN = 0,
  parameter int unsigned RANGE_MAX = 2**WIDTH - 2,
  parameter int unsigned SHIFTS_PER_DRAW = WIDTH,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             busy,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic [WIDTH-1:0] raw,
  output logic             lockup,
  output logic [1:0]       fsm_state
);

  // Handshake: req is sampled only while busy==0 (IDLE/DONE edge into IDLE decides); a req
  // seen while busy is dropped. rand_valid is a single-cycle pulse and rand_out is stable
  // from that pulse until the next one.
  localparam int SW = $clog2(SHIFTS_PER_DRAW + 1);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [SW-1:0] LAST_SHIFT = SW'(SHIFTS_PER_DRAW - 1);
  localparam logic [TW-1:0] LAST_TRY   = TW'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(RANGE_MIN);
  localparam logic [WIDTH-1:0] SPAN    = WIDTH'(RANGE_MAX - RANGE_MIN);

  lfsr_state_e state, state_n;
  logic [SW-1:0] shift_cnt, shift_n;
  logic [TW-1:0] tries, tries_n;
  logic [WIDTH-1:0] rand_n;
  logic [WIDTH-1:0] offset;
  logic fsm_step, in_range;

  // Wrap-around subtraction turns the two-sided bound into a single unsigned compare.
  assign offset   = raw - MIN_V;
  assign in_range = (offset <= SPAN);

  assign busy      = (state == SHIFT) || (state == CHECK);
  assign fsm_state = state;

  lfsr_core #(
    .WIDTH(WIDTH),
    .TAPS(TAPS),
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_core (
    .clk(clk),
    .reset(reset),
    .load(seed_load),
    .seed(seed),
    .step(fsm_step | (en & ~busy)),
    .raw(raw),
    .lockup(lockup)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_cnt  <= '0;
      tries      <= '0;
      rand_out   <= MIN_V;
      rand_valid <= 1'b0;
    end else begin
      state      <= state_n;
      shift_cnt  <= shift_n;
      tries      <= tries_n;
      rand_out   <= rand_n;
      rand_valid <= (state == DONE);
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift_cnt;
    tries_n  = tries;
    rand_n   = rand_out;
    fsm_step = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = SHIFT;
          shift_n = '0;
          tries_n = '0;
        end
      end
      SHIFT: begin
        fsm_step = 1'b1;
        shift_n  = shift_cnt + 1'b1;
        if (shift_cnt == LAST_SHIFT) state_n = CHECK;
      end
      CHECK: begin
        if (in_range) begin
          rand_n  = raw;
          state_n = DONE;
        end else if (tries == LAST_TRY) begin
          rand_n  = MIN_V;
          state_n = DONE;
        end else begin
          tries_n = tries + 1'b1;
          shift_n = '0;
          state_n = SHIFT;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Bench for lfsr_rand_range: sequence, period, bounded draws, fallback, seeding, reset, lock-up.
module tb_lfsr_rand_range;

  localparam int W = 10;
  localparam int unsigned TAPS_M = 10'h240;
  localparam int unsigned S = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic en_a, seed_load_a, req_a, busy_a, rand_valid_a, lockup_a;
  logic [W-1:0] seed_a, rand_out_a, raw_a;
  logic [1:0] fsm_state_a;
  logic en_b, seed_load_b, req_b, busy_b, rand_valid_b, lockup_b;
  logic [W-1:0] seed_b, rand_out_b, raw_b;
  logic [1:0] fsm_state_b;

  lfsr_rand_range #(.WIDTH(W), .RANGE_MIN(100), .RANGE_MAX(400),
                    .SHIFTS_PER_DRAW(S), .MAX_TRIES(8)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .seed_load(seed_load_a), .seed(seed_a),
    .req(req_a), .busy(busy_a), .rand_valid(rand_valid_a), .rand_out(rand_out_a),
    .raw(raw_a), .lockup(lockup_a), .fsm_state(fsm_state_a));

  lfsr_rand_range #(.WIDTH(W), .RANGE_MIN(10'h3FE), .RANGE_MAX(10'h3FE),
                    .SHIFTS_PER_DRAW(S), .MAX_TRIES(2)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .seed_load(seed_load_b), .seed(seed_b),
    .req(req_b), .busy(busy_b), .rand_valid(rand_valid_b), .rand_out(rand_out_b),
    .raw(raw_b), .lockup(lockup_b), .fsm_state(fsm_state_b));

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_a = 0; seed_load_a = 0; seed_a = '0; req_a = 0;
    en_b = 0; seed_load_b = 0; seed_b = '0; req_b = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference: parity of tapped bits, XNOR means feedback 1 when the count is even.
  function automatic int unsigned m_next(input int unsigned r);
    int ones = 0;
    for (int i = 0; i < W; i++)
      if (((r >> i) & 1) == 1 && ((TAPS_M >> i) & 1) == 1) ones++;
    return ((r * 2) + ((ones % 2 == 0) ? 1 : 0)) % (1 << W);
  endfunction

  function automatic void m_draw(input int unsigned r0, input int unsigned mn,
                                 input int unsigned mx, input int unsigned mt,
                                 output int unsigned val, output int unsigned k,
                                 output int unsigned r_end);
    int unsigned r = r0;
    for (int a = 1; a <= int'(mt); a++) begin
      for (int j = 0; j < int'(S); j++) r = m_next(r);
      if (r >= mn && r <= mx) begin
        val = r; k = a; r_end = r;
        return;
      end
    end
    val = mn; k = mt; r_end = r;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mraw, exp_val, exp_k, r_end, cnt, errs, hits, n;
    logic got;
    logic [W-1:0] seq_exp [8];
    seq_exp = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};

    do_reset();
    check("rst_raw", raw_a, 0);
    check("rst_rand_out_a", rand_out_a, 100);
    check("rst_rand_out_b", rand_out_b, 10'h3FE);
    check("rst_busy", busy_a, 0);
    check("rst_valid", rand_valid_a, 0);
    check("rst_lockup", lockup_a, 0);

    // Raw sequence from the default seed.
    mraw = 0;
    en_a = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      mraw = m_next(mraw);
      check("seq_model", raw_a, mraw);
      check("seq_table", raw_a, seq_exp[i]);
    end

    // Full period: 1023 steps back to zero, never hitting all-ones.
    do_reset();
    mraw = 0; errs = 0; hits = 0;
    en_a = 1;
    for (int i = 0; i < 1023; i++) begin
      tick();
      mraw = m_next(mraw);
      if (raw_a !== W'(mraw)) errs++;
      if (raw_a === 10'h3FF) hits++;
    end
    en_a = 0;
    check("period_model_errs", errs, 0);
    check("period_allones", hits, 0);
    check("period_wrap", raw_a, 0);

    // Bounded draws with random seeding, idle stepping and en pressure while busy.
    for (int d = 0; d < 200; d++) begin
      if ($urandom_range(0, 3) == 0) begin
        seed_load_a = 1; seed_a = W'($urandom_range(0, 1022));
        tick();
        seed_load_a = 0;
        mraw = seed_a;
      end
      n = $urandom_range(0, 3);
      en_a = 1;
      for (int i = 0; i < int'(n); i++) begin
        tick();
        mraw = m_next(mraw);
      end
      en_a = 0;
      m_draw(mraw, 100, 400, 8, exp_val, exp_k, r_end);
      req_a = 1;
      tick();
      req_a = 0;
      cnt = 0; got = 0;
      while (!got && cnt < 150) begin
        en_a = (cnt + 1 <= S) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (cnt == 2) req_a = 1;
        tick();
        req_a = 0;
        cnt++;
        if (rand_valid_a) got = 1;
      end
      en_a = 0;
      check("draw_valid", got, 1);
      check("draw_latency", cnt, exp_k * (S + 1) + 1);
      check("draw_value", rand_out_a, exp_val);
      check("draw_range", (rand_out_a >= 100 && rand_out_a <= 400), 1);
      check("draw_busy", busy_a, 0);
      mraw = r_end;
      check("draw_raw", raw_a, mraw);
      tick();
      check("draw_pulse", rand_valid_a, 0);
    end

    // Seed load wins over en in the same cycle.
    seed_load_a = 1; seed_a = 10'h155; en_a = 1;
    tick();
    seed_load_a = 0; en_a = 0;
    check("seed_vs_en", raw_a, 10'h155);

    // Reset in the middle of a draw abandons it.
    req_a = 1;
    tick();
    req_a = 0;
    repeat (3) tick();
    check("mid_busy", busy_a, 1);
    reset = 1'b1;
    #1;
    check("async_busy", busy_a, 0);
    check("async_raw", raw_a, 0);
    repeat (2) tick();
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rand_valid_a) hits++;
    end
    check("abandon_no_valid", hits, 0);

    // Fallback path: target value never reached, two attempts.
    do_reset();
    m_draw(0, 10'h3FE, 10'h3FE, 2, exp_val, exp_k, r_end);
    req_b = 1;
    tick();
    req_b = 0;
    cnt = 0; got = 0;
    while (!got && cnt < 150) begin
      tick();
      cnt++;
      if (rand_valid_b) got = 1;
    end
    check("fb_valid", got, 1);
    check("fb_latency_model", cnt, exp_k * (S + 1) + 1);
    check("fb_latency", cnt, 23);
    check("fb_value", rand_out_b, 10'h3FE);
    check("fb_raw", raw_b, r_end);

    // All-ones seed behaviour.
    do_reset();
    seed_load_a = 1; seed_a = 10'h3FF;
    tick();
    seed_load_a = 0;
    check("ones_loaded", raw_a, 10'h3FF);
    check("ones_no_lockup", lockup_a, 0);
    en_a = 1;
    tick();
    en_a = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("recover_raw", raw_a, 0);
    check("recover_lockup", lockup_a, 1);
    tick();
    check("recover_pulse", lockup_a, 0);
`else
    check("stuck_raw", raw_a, 10'h3FF);
    check("stuck_lockup", lockup_a, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
